// File: rtl/icache_pkg.sv
// Shared types and helpers for the direct-mapped instruction cache.
// Holds the controller state encoding and the default index width.
package icache_pkg;

   localparam int INDEX_W_DEF = 8;

   typedef enum logic [1:0] {
      IC_IDLE  = 2'd0,
      IC_FETCH = 2'd1,
      IC_DONE  = 2'd2
   } state_t;

   // Word-aligned byte address of the line holding pc.
   function automatic logic [31:0] word_base(input logic [31:0] pc);
      return pc & ~32'h3;
   endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the instruction cache: combinational read by
// index, synchronous single-line write, synchronous clear of all valid bits.
module icache_array
   import icache_pkg::*;
#(
   parameter int INDEX_W = INDEX_W_DEF,
   localparam int TAG_W = 30 - INDEX_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               we,
   input  logic [INDEX_W-1:0] w_index,
   input  logic [TAG_W-1:0]   w_tag,
   input  logic [31:0]        w_data,
   input  logic [INDEX_W-1:0] r_index,
   output logic               r_valid,
   output logic [TAG_W-1:0]   r_tag,
   output logic [31:0]        r_data
);

   localparam int LINES = 1 << INDEX_W;

   logic [LINES-1:0] valid;
   logic [TAG_W-1:0] tag_mem  [LINES];
   logic [31:0]      data_mem [LINES];

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= '0;
      end else if (we) begin
         valid[w_index] <= 1'b1;
      end
   end

   // NOTE: tag/data storage has no reset; the valid bits alone qualify it,
   // which keeps these arrays mappable onto plain RAM.
   always_ff @(posedge clk) begin
      if (we) begin
         tag_mem[w_index]  <= w_tag;
         data_mem[w_index] <= w_data;
      end
   end

   assign r_valid = valid[r_index];
   assign r_tag   = tag_mem[r_index];
   assign r_data  = data_mem[r_index];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache: answers fetch requests on a hit, otherwise
// assembles the word from four byte reads through the memory arbiter.
module icache
   import icache_pkg::*;
#(
   parameter int INDEX_W = INDEX_W_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        nd_ins,
   input  logic [31:0] pc_fetch,
   input  logic        jal_reset,
   output logic        flg_get,
   output logic [31:0] ins_out,
   output logic        mem_req,
   input  logic        mem_gnt,
   output logic [31:0] mem_a,
   input  logic [7:0]  mem_din
);

   localparam int TAG_W = 30 - INDEX_W;

   state_t      state, state_d;
   logic [2:0]  ic, ic_d;
   logic [1:0]  rc, rc_d;
   logic        issued, issued_d;
   logic [31:0] base, base_d;
   logic [31:0] word, word_d;
   logic [31:0] mem_a_d;
   logic [31:0] ins_out_d;
   logic        mem_req_d;
   logic        flg_get_d;
   logic        fill;

   logic             rd_valid;
   logic [TAG_W-1:0] rd_tag;
   logic [31:0]      rd_data;
   logic             hit;

   icache_array #(.INDEX_W(INDEX_W)) u_array (
      .clk     (clk),
      .rst     (rst),
      .we      (fill && rdy && !rst),
      .w_index (base[INDEX_W+1:2]),
      .w_tag   (base[31:INDEX_W+2]),
      .w_data  (word_d),
      .r_index (pc_fetch[INDEX_W+1:2]),
      .r_valid (rd_valid),
      .r_tag   (rd_tag),
      .r_data  (rd_data)
   );

   assign hit = rd_valid && (rd_tag == pc_fetch[31:INDEX_W+2]);

   // NOTE: every signal written here gets a default first, so no path
   // through the case leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d   = state;
      ic_d      = ic;
      rc_d      = rc;
      issued_d  = 1'b0;
      base_d    = base;
      word_d    = word;
      mem_a_d   = mem_a;
      mem_req_d = mem_req;
      flg_get_d = 1'b0;
      ins_out_d = ins_out;
      fill      = 1'b0;

      if (jal_reset) begin
         state_d   = IC_IDLE;
         mem_req_d = 1'b0;
      end else begin
         case (state)
            IC_IDLE: begin
               if (nd_ins && !flg_get) begin
                  if (hit) begin
                     flg_get_d = 1'b1;
                     ins_out_d = rd_data;
                  end else begin
                     base_d    = word_base(pc_fetch);
                     mem_a_d   = word_base(pc_fetch);
                     ic_d      = '0;
                     rc_d      = '0;
                     mem_req_d = 1'b1;
                     state_d   = IC_FETCH;
                  end
               end
            end
            IC_FETCH: begin
               // mem_a always shows B+ic so it is ready whenever grant arrives.
               if (mem_gnt && ic < 3'd4) begin
                  ic_d     = ic + 3'd1;
                  issued_d = 1'b1;
                  mem_a_d  = base + {29'd0, ic_d};
               end
               if (issued) begin
                  word_d[{rc, 3'b000} +: 8] = mem_din;
                  rc_d = rc + 2'd1;
                  if (rc == 2'd3) begin
                     fill      = 1'b1;
                     state_d   = IC_DONE;
                     mem_req_d = 1'b0;
                     flg_get_d = 1'b1;
                     ins_out_d = word_d;
                  end
               end
            end
            IC_DONE: state_d = IC_IDLE;
            default: state_d = IC_IDLE;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IC_IDLE;
         ic      <= '0;
         rc      <= '0;
         issued  <= 1'b0;
         base    <= '0;
         word    <= '0;
         mem_a   <= '0;
         mem_req <= 1'b0;
         flg_get <= 1'b0;
         ins_out <= '0;
      end else if (rdy) begin
         state   <= state_d;
         ic      <= ic_d;
         rc      <= rc_d;
         issued  <= issued_d;
         base    <= base_d;
         word    <= word_d;
         mem_a   <= mem_a_d;
         mem_req <= mem_req_d;
         flg_get <= flg_get_d;
         ins_out <= ins_out_d;
      end
   end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus randomized requests
// checked against a line-level cache model and a hashed RAM image.
module tb_icache;

   logic        clk;
   logic        rst;
   logic        rdy;
   logic        nd_ins;
   logic [31:0] pc_fetch;
   logic        jal_reset;
   logic        flg_get;
   logic [31:0] ins_out;
   logic        mem_req;
   logic        mem_gnt;
   logic [31:0] mem_a;
   logic [7:0]  mem_din;

   int vectors     = 0;
   int miscompares = 0;

   // Cache model: INDEX_W = 8, tag = addr[31:10].
   logic        mvalid [256];
   logic [21:0] mtag   [256];

   typedef struct {
      int          lat;
      logic [31:0] data;
      int          issues;
      int          bad_addr;
      int          frozen_bad;
      logic        req_early;
      logic        req_seen;
      logic        req_after_abort;
      logic        tail_bad;
   } res_t;

   icache dut (
      .clk       (clk),
      .rst       (rst),
      .rdy       (rdy),
      .nd_ins    (nd_ins),
      .pc_fetch  (pc_fetch),
      .jal_reset (jal_reset),
      .flg_get   (flg_get),
      .ins_out   (ins_out),
      .mem_req   (mem_req),
      .mem_gnt   (mem_gnt),
      .mem_a     (mem_a),
      .mem_din   (mem_din)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] ram_rd(input logic [31:0] a);
      logic [31:0] h;
      case (a)
         32'h1000: return 8'h13;
         32'h1001: return 8'h05;
         32'h1002: return 8'h00;
         32'h1003: return 8'h00;
         default: begin
            h = a * 32'h9E37_79B1;
            return h[31:24] ^ h[15:8];
         end
      endcase
   endfunction

   function automatic logic [31:0] exp_word(input logic [31:0] addr);
      logic [31:0] b;
      b = addr & ~32'h3;
      return {ram_rd(b + 32'd3), ram_rd(b + 32'd2), ram_rd(b + 32'd1), ram_rd(b)};
   endfunction

   function automatic bit in_win(input int k, input int at, input int len);
      return (k >= at) && (k < at + len);
   endfunction

   // A miss needs four cycles that are both granted and ready; the last byte
   // lands on the next ready cycle and the answer appears one cycle later.
   function automatic int exp_miss_lat(input int gnt_at, input int gnt_len,
                                       input int rdy_at, input int rdy_len);
      int n;
      int k;
      n = 0;
      k = 1;
      while (n < 4) begin
         if (!in_win(k, gnt_at, gnt_len) && !in_win(k, rdy_at, rdy_len)) n++;
         k++;
      end
      while (in_win(k, rdy_at, rdy_len)) k++;
      return k + 1;
   endfunction

   function automatic bit model_hit(input logic [31:0] addr);
      return mvalid[addr[9:2]] && (mtag[addr[9:2]] == addr[31:10]);
   endfunction

   function automatic void model_fill(input logic [31:0] addr);
      mvalid[addr[9:2]] = 1'b1;
      mtag[addr[9:2]]   = addr[31:10];
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < 256; i++) mvalid[i] = 1'b0;
   endfunction

   // Drives one request (cycle 0) and plays the arbiter and RAM until the
   // answer arrives or the cycle budget runs out (lat stays -1).
   task automatic run_req(input logic [31:0] addr, input int gnt_at, input int gnt_len,
                          input int rdy_at, input int rdy_len, input int abort_at,
                          output res_t r);
      logic [31:0] b;
      logic [31:0] prev_a;
      logic [31:0] last_a;
      logic        prev_issue;
      logic        prev_rdy;
      b = addr & ~32'h3;
      r = '{default: 0};
      r.lat = -1;
      prev_issue = 1'b0;
      prev_rdy   = 1'b1;
      prev_a     = '0;
      last_a     = '0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (k > 0 && flg_get === 1'b1) begin
            r.lat  = k;
            r.data = ins_out;
         end
         if (mem_req === 1'b1) begin
            if (k == 0) r.req_early = 1'b1;
            if (abort_at >= 0 && k > abort_at) r.req_after_abort = 1'b1;
            r.req_seen = 1'b1;
         end
         if (!prev_rdy && mem_a !== last_a) r.frozen_bad++;
         last_a = mem_a;
         if (prev_issue) mem_din = ram_rd(prev_a);
         nd_ins    = (k == 0);
         pc_fetch  = addr;
         mem_gnt   = !in_win(k, gnt_at, gnt_len);
         rdy       = !in_win(k, rdy_at, rdy_len);
         jal_reset = (k == abort_at);
         prev_rdy  = rdy;
         prev_issue = 1'b0;
         if (mem_req === 1'b1 && mem_gnt && rdy && r.issues < 4) begin
            if (mem_a !== b + 32'(r.issues)) r.bad_addr++;
            prev_issue = 1'b1;
            prev_a     = mem_a;
            r.issues++;
         end
         if (r.lat >= 0) break;
      end
      @(negedge clk);
      if (flg_get !== 1'b0 || mem_req !== 1'b0) r.tail_bad = 1'b1;
      nd_ins    = 1'b0;
      jal_reset = 1'b0;
      mem_gnt   = 1'b1;
      rdy       = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      vectors++;
      if (flg_get !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_flg_get: got %b expected 0", flg_get);
      end
      vectors++;
      if (ins_out !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_ins_out: got %h expected 00000000", ins_out);
      end
      vectors++;
      if (mem_req !== 1'b0 || mem_a !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_mem: got req=%b a=%h expected req=0 a=00000000", mem_req, mem_a);
      end
      rst = 1'b0;
      model_clear();
   endtask

   task automatic test_cold_miss();
      res_t r;
      run_req(32'h1000, 0, 0, 0, 0, -1, r);
      vectors++;
      if (r.lat !== 6) begin
         miscompares++;
         $display("FAIL cold_latency: got %0d expected 6", r.lat);
      end
      vectors++;
      if (r.data !== 32'h0000_0513) begin
         miscompares++;
         $display("FAIL cold_data: got %h expected 00000513", r.data);
      end
      vectors++;
      if (r.bad_addr !== 0 || r.issues !== 4) begin
         miscompares++;
         $display("FAIL cold_addr: got %0d bad of %0d issues expected 0 of 4", r.bad_addr, r.issues);
      end
      vectors++;
      if (r.req_early !== 1'b0 || r.tail_bad !== 1'b0) begin
         miscompares++;
         $display("FAIL cold_req_window: got early=%b tail=%b expected 0 0", r.req_early, r.tail_bad);
      end
      model_fill(32'h1000);
   endtask

   task automatic test_warm_hit();
      res_t r;
      run_req(32'h1000, 0, 0, 0, 0, -1, r);
      vectors++;
      if (r.lat !== 1) begin
         miscompares++;
         $display("FAIL hit_latency: got %0d expected 1", r.lat);
      end
      vectors++;
      if (r.data !== 32'h0000_0513) begin
         miscompares++;
         $display("FAIL hit_data: got %h expected 00000513", r.data);
      end
      vectors++;
      if (r.req_seen !== 1'b0 || r.tail_bad !== 1'b0) begin
         miscompares++;
         $display("FAIL hit_mem_req: got req=%b tail=%b expected 0 0", r.req_seen, r.tail_bad);
      end
   endtask

   task automatic test_conflict();
      res_t r;
      run_req(32'h1400, 0, 0, 0, 0, -1, r);
      vectors++;
      if (r.lat !== 6 || r.data !== exp_word(32'h1400)) begin
         miscompares++;
         $display("FAIL evict_fill: got lat=%0d data=%h expected lat=6 data=%h",
                  r.lat, r.data, exp_word(32'h1400));
      end
      model_fill(32'h1400);
      run_req(32'h1000, 0, 0, 0, 0, -1, r);
      vectors++;
      if (r.lat !== 6 || r.data !== 32'h0000_0513) begin
         miscompares++;
         $display("FAIL evict_refill: got lat=%0d data=%h expected lat=6 data=00000513",
                  r.lat, r.data);
      end
      model_fill(32'h1000);
   endtask

   task automatic test_grant_gap();
      res_t r;
      run_req(32'h3010, 3, 2, 0, 0, -1, r);
      vectors++;
      if (r.lat !== 8) begin
         miscompares++;
         $display("FAIL gap_latency: got %0d expected 8", r.lat);
      end
      vectors++;
      if (r.data !== exp_word(32'h3010) || r.bad_addr !== 0) begin
         miscompares++;
         $display("FAIL gap_data: got %h (bad addr %0d) expected %h (0)",
                  r.data, r.bad_addr, exp_word(32'h3010));
      end
      model_fill(32'h3010);
   endtask

   task automatic test_abort();
      res_t r;
      run_req(32'h4020, 0, 0, 0, 0, 5, r);
      vectors++;
      if (r.lat !== -1) begin
         miscompares++;
         $display("FAIL abort_no_get: got flg_get at %0d expected none", r.lat);
      end
      vectors++;
      if (r.req_after_abort !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_mem_req: got %b expected 0 after abort", r.req_after_abort);
      end
      run_req(32'h4020, 0, 0, 0, 0, -1, r);
      vectors++;
      if (r.lat !== 6 || r.data !== exp_word(32'h4020)) begin
         miscompares++;
         $display("FAIL abort_refetch: got lat=%0d data=%h expected lat=6 data=%h",
                  r.lat, r.data, exp_word(32'h4020));
      end
      model_fill(32'h4020);
   endtask

   task automatic test_rdy_freeze();
      res_t r;
      run_req(32'h5040, 0, 0, 3, 3, -1, r);
      vectors++;
      if (r.lat !== 9) begin
         miscompares++;
         $display("FAIL rdy_latency: got %0d expected 9", r.lat);
      end
      vectors++;
      if (r.data !== exp_word(32'h5040) || r.bad_addr !== 0 || r.frozen_bad !== 0) begin
         miscompares++;
         $display("FAIL rdy_result: got %h bad=%0d moved=%0d expected %h 0 0",
                  r.data, r.bad_addr, r.frozen_bad, exp_word(32'h5040));
      end
      model_fill(32'h5040);
   endtask

   task automatic test_reset_mid();
      res_t r;
      @(negedge clk);
      nd_ins   = 1'b1;
      pc_fetch = 32'h6000;
      mem_gnt  = 1'b1;
      @(negedge clk);
      nd_ins = 1'b0;
      @(negedge clk);
      vectors++;
      if (mem_req !== 1'b1) begin
         miscompares++;
         $display("FAIL midrst_fetching: got mem_req=%b expected 1", mem_req);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      vectors++;
      if (flg_get !== 1'b0 || mem_req !== 1'b0 || mem_a !== 32'h0 || ins_out !== 32'h0) begin
         miscompares++;
         $display("FAIL midrst_outputs: got get=%b req=%b a=%h ins=%h expected all zero",
                  flg_get, mem_req, mem_a, ins_out);
      end
      model_clear();
      run_req(32'h1000, 0, 0, 0, 0, -1, r);
      vectors++;
      if (r.lat !== 6 || r.data !== 32'h0000_0513) begin
         miscompares++;
         $display("FAIL midrst_invalid: got lat=%0d data=%h expected lat=6 data=00000513",
                  r.lat, r.data);
      end
      model_fill(32'h1000);
   endtask

   task automatic test_random();
      logic [31:0] pool [8];
      logic [31:0] addr;
      res_t r;
      int ga, gl, ra, rl, exp_lat;
      pool = '{32'h1000, 32'h1400, 32'h1004, 32'h2008, 32'h3C0C, 32'h800C, 32'h1002, 32'h7FF0};
      for (int n = 0; n < 40; n++) begin
         addr = pool[$urandom_range(0, 7)];
         if (model_hit(addr)) begin
            ga = 0; gl = 0; ra = 0; rl = 0;
            exp_lat = 1;
         end else begin
            ga = $urandom_range(1, 6);
            gl = $urandom_range(0, 3);
            ra = $urandom_range(1, 4);
            rl = $urandom_range(0, 3);
            exp_lat = exp_miss_lat(ga, gl, ra, rl);
         end
         run_req(addr, ga, gl, ra, rl, -1, r);
         vectors++;
         if (r.lat !== exp_lat || r.data !== exp_word(addr)) begin
            miscompares++;
            $display("FAIL rand_%0d %h: got lat=%0d data=%h expected lat=%0d data=%h",
                     n, addr, r.lat, r.data, exp_lat, exp_word(addr));
         end
         vectors++;
         if (r.bad_addr !== 0 || r.frozen_bad !== 0 || r.tail_bad !== 1'b0) begin
            miscompares++;
            $display("FAIL rand_bus_%0d %h: got bad=%0d moved=%0d tail=%b expected 0 0 0",
                     n, addr, r.bad_addr, r.frozen_bad, r.tail_bad);
         end
         model_fill(addr);
      end
   endtask

   initial begin
      rst       = 1'b1;
      rdy       = 1'b1;
      nd_ins    = 1'b0;
      pc_fetch  = '0;
      jal_reset = 1'b0;
      mem_gnt   = 1'b0;
      mem_din   = '0;
      test_reset();
      test_cold_miss();
      test_warm_hit();
      test_conflict();
      test_grant_gap();
      test_abort();
      test_rdy_freeze();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
